mmc_sector_sequencer: RTL and testbench

MMC_SECTOR_SEQUENCER -- requirements
Module: mmc_sector_sequencer

---
 rtl/mmc_sector_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mmc_sector_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_sector_sequencer.sv
// MMC sector sequencer: moves one 512-byte sector between a byte stream and a
// 128x32 word buffer, sharing the buffer with a host port. Define MMC_SEQ_CRC16_EN for the sector CRC16.
module mmc_sector_sequencer (
   input  logic        iCLOCK,
   input  logic        iRESET_SYNC,
   input  logic        iCMD_START_RX,
   input  logic        iCMD_START_TX,
   output logic        oBUSY,
   output logic        oDONE,
   output logic [9:0]  oBYTE_COUNT,
   input  logic        iRX_VALID,
   input  logic [7:0]  iRX_BYTE,
   output logic        oTX_VALID,
   output logic [7:0]  oTX_BYTE,
   input  logic        iTX_READY,
   input  logic        iHOST_REQ,
   input  logic        iHOST_RW,
   input  logic [6:0]  iHOST_ADDR,
   input  logic [3:0]  iHOST_MASK,
   input  logic [31:0] iHOST_DATA,
   output logic        oHOST_ACK,
   output logic [31:0] oHOST_DATA,
   output logic        oBUF_WR_REQ,
   output logic [3:0]  oBUF_WR_MASK,
   output logic [6:0]  oBUF_WR_ADDR,
   output logic [31:0] oBUF_WR_DATA,
   output logic [6:0]  oBUF_RD_ADDR,
   input  logic [31:0] iBUF_RD_DATA,
   output logic [15:0] oCRC16
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RX   = 2'd1,
      ST_TX   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t      state_p0;
   state_t      state_nxt;
   logic [9:0]  cnt_p0;
   logic        vld_p0;
   logic [31:0] host_data_p0;

   logic [6:0]  word_idx;
   logic [1:0]  lane_idx;
   logic        rx_move;
   logic        tx_move;
   logic        byte_move;
   logic        last_byte;
   logic        start_any;
   logic        host_own;
   logic        host_acc;

   // Big-endian lane pick: lane 0 is the most significant byte.
   function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   assign word_idx  = cnt_p0[8:2];
   assign lane_idx  = cnt_p0[1:0];
   assign rx_move   = (state_p0 == ST_RX) && iRX_VALID;
   assign tx_move   = (state_p0 == ST_TX) && iTX_READY;
   assign byte_move = rx_move || tx_move;
   assign last_byte = byte_move && (cnt_p0[8:0] == 9'h1FF);
   assign start_any = (state_p0 == ST_IDLE) && (iCMD_START_RX || iCMD_START_TX);
   assign host_own  = (state_p0 == ST_IDLE) || (state_p0 == ST_DONE);
   // The ack cycle never re-accepts, so a request held into its ack is serviced once.
   assign host_acc  = host_own && iHOST_REQ && !vld_p0 && !start_any;

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC)
         state_p0 <= ST_IDLE;
      else
         state_p0 <= state_nxt;
   end

   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         ST_IDLE: begin
            if (iCMD_START_RX)
               state_nxt = ST_RX;
            else if (iCMD_START_TX)
               state_nxt = ST_TX;
         end
         ST_RX, ST_TX: begin
            if (last_byte)
               state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      oBUSY        = 1'b0;
      oDONE        = 1'b0;
      oTX_VALID    = 1'b0;
      oTX_BYTE     = 8'h00;
      oBUF_WR_REQ  = 1'b0;
      oBUF_WR_MASK = 4'hF;
      oBUF_WR_ADDR = iHOST_ADDR;
      oBUF_WR_DATA = iHOST_DATA;
      oBUF_RD_ADDR = iHOST_ADDR;
      case (state_p0)
         ST_RX: begin
            oBUSY        = 1'b1;
            oBUF_WR_REQ  = iRX_VALID;
            oBUF_WR_MASK = ~(4'b1000 >> lane_idx);
            oBUF_WR_ADDR = word_idx;
            oBUF_WR_DATA = {4{iRX_BYTE}};
            oBUF_RD_ADDR = word_idx;
         end
         ST_TX: begin
            oBUSY        = 1'b1;
            oTX_VALID    = 1'b1;
            oTX_BYTE     = lane_sel(iBUF_RD_DATA, lane_idx);
            oBUF_WR_DATA = 32'h0000_0000;
            oBUF_RD_ADDR = word_idx;
         end
         ST_DONE: begin
            oDONE        = 1'b1;
            oBUF_WR_REQ  = host_acc && iHOST_RW;
            oBUF_WR_MASK = iHOST_MASK;
         end
         default: begin
            oBUF_WR_REQ  = host_acc && iHOST_RW;
            oBUF_WR_MASK = iHOST_MASK;
         end
      endcase
   end

   // Stage p0: byte counter, host ack and registered host read data.
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         cnt_p0       <= 10'd0;
         vld_p0       <= 1'b0;
         host_data_p0 <= 32'h0000_0000;
      end else begin
         if (start_any)
            cnt_p0 <= 10'd0;
         else if (byte_move)
            cnt_p0 <= cnt_p0 + 10'd1;
         vld_p0 <= host_acc;
         if (host_acc && !iHOST_RW)
            host_data_p0 <= iBUF_RD_DATA;
      end
   end

   assign oBYTE_COUNT = cnt_p0;
   assign oHOST_ACK   = vld_p0;
   assign oHOST_DATA  = host_data_p0;

`ifdef MMC_SEQ_CRC16_EN
   logic [15:0] crc_p0;
   logic [7:0]  crc_byte;

   // Bit-serial CRC16-CCITT, MSB of the byte first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         fb = c[15] ^ data[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   assign crc_byte = (state_p0 == ST_RX) ? iRX_BYTE : oTX_BYTE;

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC)
         crc_p0 <= 16'h0000;
      else if (start_any)
         crc_p0 <= 16'h0000;
      else if (byte_move)
         crc_p0 <= crc16_byte(crc_p0, crc_byte);
   end

   assign oCRC16 = crc_p0;
`else
   assign oCRC16 = 16'h0000;
`endif

endmodule

// File: tb/tb_mmc_sector_sequencer.sv
// Bench for mmc_sector_sequencer: vector table, directed sector sequences and
// randomized transfers against a byte-addressed buffer model.
module tb_mmc_sector_sequencer;

   logic        iCLOCK = 1'b0;
   logic        iRESET_SYNC;
   logic        iCMD_START_RX, iCMD_START_TX;
   logic        oBUSY, oDONE;
   logic [9:0]  oBYTE_COUNT;
   logic        iRX_VALID;
   logic [7:0]  iRX_BYTE;
   logic        oTX_VALID;
   logic [7:0]  oTX_BYTE;
   logic        iTX_READY;
   logic        iHOST_REQ, iHOST_RW;
   logic [6:0]  iHOST_ADDR;
   logic [3:0]  iHOST_MASK;
   logic [31:0] iHOST_DATA;
   logic        oHOST_ACK;
   logic [31:0] oHOST_DATA;
   logic        oBUF_WR_REQ;
   logic [3:0]  oBUF_WR_MASK;
   logic [6:0]  oBUF_WR_ADDR;
   logic [31:0] oBUF_WR_DATA;
   logic [6:0]  oBUF_RD_ADDR;
   logic [31:0] iBUF_RD_DATA;
   logic [15:0] oCRC16;

`ifdef MMC_SEQ_CRC16_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   mmc_sector_sequencer dut (
      .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC),
      .iCMD_START_RX(iCMD_START_RX), .iCMD_START_TX(iCMD_START_TX),
      .oBUSY(oBUSY), .oDONE(oDONE), .oBYTE_COUNT(oBYTE_COUNT),
      .iRX_VALID(iRX_VALID), .iRX_BYTE(iRX_BYTE),
      .oTX_VALID(oTX_VALID), .oTX_BYTE(oTX_BYTE), .iTX_READY(iTX_READY),
      .iHOST_REQ(iHOST_REQ), .iHOST_RW(iHOST_RW), .iHOST_ADDR(iHOST_ADDR),
      .iHOST_MASK(iHOST_MASK), .iHOST_DATA(iHOST_DATA),
      .oHOST_ACK(oHOST_ACK), .oHOST_DATA(oHOST_DATA),
      .oBUF_WR_REQ(oBUF_WR_REQ), .oBUF_WR_MASK(oBUF_WR_MASK),
      .oBUF_WR_ADDR(oBUF_WR_ADDR), .oBUF_WR_DATA(oBUF_WR_DATA),
      .oBUF_RD_ADDR(oBUF_RD_ADDR), .iBUF_RD_DATA(iBUF_RD_DATA),
      .oCRC16(oCRC16)
   );

   always #5 iCLOCK = ~iCLOCK;

   // Word buffer attached to the DUT: combinational read, byte-masked write.
   logic [31:0] buf_mem [128];
   assign iBUF_RD_DATA = buf_mem[oBUF_RD_ADDR];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (!m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   always @(posedge iCLOCK)
      if (oBUF_WR_REQ)
         buf_mem[oBUF_WR_ADDR] <= merge(buf_mem[oBUF_WR_ADDR], oBUF_WR_DATA, oBUF_WR_MASK);

   int done_cnt = 0;
   always @(negedge iCLOCK)
      if (oDONE) done_cnt <= done_cnt + 1;

   // Reference model: the sector as a plain byte array, byte n at ref_b[n].
   logic [7:0] ref_b [512];

   function automatic logic [31:0] ref_word(input int a);
      return {ref_b[4*a], ref_b[4*a+1], ref_b[4*a+2], ref_b[4*a+3]};
   endfunction

   task automatic ref_host_write(input int a, input logic [31:0] d, input logic [3:0] m);
      for (int l = 0; l < 4; l++)
         if (!m[3-l]) ref_b[4*a+l] = d[31-8*l -: 8];
   endtask

   function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int i = 0; i < 8; i++)
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge iCLOCK);
      #1;
   endtask

   task automatic host_xfer(input logic rw, input logic [6:0] a, input logic [31:0] d,
                            input logic [3:0] m, output logic [31:0] rd, output int waited);
      iHOST_REQ = 1'b1; iHOST_RW = rw; iHOST_ADDR = a; iHOST_DATA = d; iHOST_MASK = m;
      waited = 0;
      do begin
         tick();
         waited++;
      end while (!oHOST_ACK && waited < 100);
      check("host_ack", oHOST_ACK, 1);
      rd = oHOST_DATA;
      iHOST_REQ = 1'b0;
      tick();
      check("host_ack_pulse", oHOST_ACK, 0);
   endtask

   typedef struct {
      logic       srx, stx, rxv;
      logic [7:0] rxb;
      logic       e_busy, e_wr;
      logic [3:0] e_mask;
      logic [6:0] e_addr;
      logic [9:0] e_cnt;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic [31:0] rd;
      int          waited, d0, idx, cyc, n;
      logic [15:0] crc;
      logic [7:0]  prev_byte, b;
      logic        prev_rdy, ack_busy;
      logic [7:0]  exp4 [4];
      logic [31:0] d;
      logic [3:0]  m;
      logic [6:0]  a;

      tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'hF, 7'd0, 10'd0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 4'b0111, 7'd0, 10'd1};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 4'hF, 7'd0, 10'd1};
      tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 4'b1011, 7'd0, 10'd2};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 4'b1101, 7'd0, 10'd3};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 4'b1110, 7'd0, 10'd4};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 4'b0111, 7'd1, 10'd5};
      exp4[0] = 8'hDE; exp4[1] = 8'hAD; exp4[2] = 8'hBE; exp4[3] = 8'hEF;

      for (int i = 0; i < 128; i++) buf_mem[i] = 32'h0;
      for (int i = 0; i < 512; i++) ref_b[i] = 8'h00;
      iRESET_SYNC = 1'b1; iCMD_START_RX = 1'b0; iCMD_START_TX = 1'b0;
      iRX_VALID = 1'b0; iRX_BYTE = 8'h00; iTX_READY = 1'b0;
      iHOST_REQ = 1'b0; iHOST_RW = 1'b0; iHOST_ADDR = 7'd0; iHOST_MASK = 4'hF; iHOST_DATA = 32'h0;

      // Reset state
      tick(); tick();
      check("rst_busy", oBUSY, 0);
      check("rst_done", oDONE, 0);
      check("rst_tx_valid", oTX_VALID, 0);
      check("rst_wr_req", oBUF_WR_REQ, 0);
      check("rst_ack", oHOST_ACK, 0);
      check("rst_count", oBYTE_COUNT, 0);
      check("rst_host_data", oHOST_DATA, 0);
      check("rst_crc", oCRC16, 0);
      iRESET_SYNC = 1'b0;

      // Vector table: start priority, ignored starts, lane masks
      for (int i = 0; i < 7; i++) begin
         iCMD_START_RX = tbl[i].srx; iCMD_START_TX = tbl[i].stx;
         iRX_VALID = tbl[i].rxv; iRX_BYTE = tbl[i].rxb;
         #1;
         check($sformatf("tbl%0d_busy", i), oBUSY, tbl[i].e_busy);
         check($sformatf("tbl%0d_wr_req", i), oBUF_WR_REQ, tbl[i].e_wr);
         check($sformatf("tbl%0d_tx_valid", i), oTX_VALID, 0);
         if (tbl[i].e_wr) begin
            check($sformatf("tbl%0d_mask", i), oBUF_WR_MASK, tbl[i].e_mask);
            check($sformatf("tbl%0d_addr", i), oBUF_WR_ADDR, tbl[i].e_addr);
            check($sformatf("tbl%0d_data", i), oBUF_WR_DATA, {4{tbl[i].rxb}});
         end
         tick();
         check($sformatf("tbl%0d_count", i), oBYTE_COUNT, tbl[i].e_cnt);
      end
      iCMD_START_RX = 1'b0; iCMD_START_TX = 1'b0; iRX_VALID = 1'b0;
      d0 = done_cnt;
      iRESET_SYNC = 1'b1; tick(); iRESET_SYNC = 1'b0;
      check("tblrst_busy", oBUSY, 0);
      check("tblrst_count", oBYTE_COUNT, 0);
      #1;
      check("tblrst_no_done", done_cnt - d0, 0);

      // Two ramps back to back, host read of word 5 stalled behind the sector
      d0 = done_cnt; crc = 16'h0; ack_busy = 1'b0;
      iCMD_START_RX = 1'b1; iHOST_REQ = 1'b1; iHOST_RW = 1'b0; iHOST_ADDR = 7'd5;
      tick();
      check("start_wins_no_ack", oHOST_ACK, 0);
      check("start_wins_busy", oBUSY, 1);
      iCMD_START_RX = 1'b0;
      for (int i = 0; i < 512; i++) begin
         iRX_VALID = 1'b1; iRX_BYTE = i[7:0];
         ref_b[i] = i[7:0]; crc = crc_model(crc, i[7:0]);
         #1;
         if (oHOST_ACK) ack_busy = 1'b1;
         tick();
      end
      iRX_VALID = 1'b0;
      #1;
      check("ramp_no_ack_busy", ack_busy, 0);
      check("ramp_no_early_done", done_cnt - d0, 0);
      check("ramp_done_at_512", oDONE, 1);
      check("ramp_busy_in_done", oBUSY, 0);
      check("ramp_count_done", oBYTE_COUNT, 10'd512);
      check("ramp_crc", oCRC16, CRC_ON ? crc : 16'h0);
      tick();
      check("ramp_ack", oHOST_ACK, 1);
      check("ramp_word5", oHOST_DATA, ref_word(5));
      check("ramp_done_pulse", oDONE, 0);
      iHOST_REQ = 1'b0;
      tick();
      check("ramp_ack_one_cycle", oHOST_ACK, 0);
      check("ramp_done_once", done_cnt - d0, 1);
      check("ramp_count_hold", oBYTE_COUNT, 10'd512);
      host_xfer(1'b0, 7'd0, 32'h0, 4'hF, rd, waited);
      check("ramp_word0", rd, 32'h00010203);
      check("ramp_ack_latency", waited, 1);
      host_xfer(1'b0, 7'd127, 32'h0, 4'hF, rd, waited);
      check("ramp_word127", rd, 32'hFCFDFEFF);
      check("ramp_crc_hold", oCRC16, CRC_ON ? crc : 16'h0);

      // 512 bytes of 0xFF
      iCMD_START_RX = 1'b1; tick(); iCMD_START_RX = 1'b0;
      check("ff_crc_cleared", oCRC16, 0);
      for (int i = 0; i < 512; i++) begin
         iRX_VALID = 1'b1; iRX_BYTE = 8'hFF; ref_b[i] = 8'hFF;
         tick();
      end
      iRX_VALID = 1'b0;
      check("ff_done", oDONE, 1);
      check("ff_crc", oCRC16, CRC_ON ? 16'h7FA1 : 16'h0);
      tick();

      // TX with ready toggling over 0xDEADBEEF
      host_xfer(1'b1, 7'd0, 32'hDEADBEEF, 4'h0, rd, waited);
      ref_host_write(0, 32'hDEADBEEF, 4'h0);
      check("tx_pre_wr_latency", waited, 1);
      iCMD_START_TX = 1'b1; tick(); iCMD_START_TX = 1'b0;
      check("tx_busy", oBUSY, 1);
      idx = 0; prev_rdy = 1'b1; prev_byte = 8'h00;
      for (int k = 0; k < 16 && idx < 4; k++) begin
         iTX_READY = (k % 2 == 1);
         #1;
         check($sformatf("tx_valid%0d", k), oTX_VALID, 1);
         if (!prev_rdy) check($sformatf("tx_hold%0d", k), oTX_BYTE, prev_byte);
         if (iTX_READY) begin
            check($sformatf("tx_byte%0d", idx), oTX_BYTE, exp4[idx]);
            idx++;
         end
         prev_byte = oTX_BYTE; prev_rdy = iTX_READY;
         tick();
      end
      check("tx_four_bytes", idx, 4);
      check("tx_no_wr", oBUF_WR_REQ, 0);
      iTX_READY = 1'b1; cyc = 0;
      while (!oDONE && cyc < 1000) begin tick(); cyc++; end
      check("tx_done", oDONE, 1);
      iTX_READY = 1'b0;
      tick();

      // Random host fill, random-ready TX against the model
      for (int i = 0; i < 128; i++) begin
         d = $urandom;
         host_xfer(1'b1, i[6:0], d, 4'h0, rd, waited);
         ref_host_write(i, d, 4'h0);
      end
      for (int i = 0; i < 24; i++) begin
         d = $urandom; m = 4'($urandom); a = 7'($urandom);
         host_xfer(1'b1, a, d, m, rd, waited);
         ref_host_write(int'(a), d, m);
      end
      for (int i = 0; i < 8; i++) begin
         a = 7'($urandom);
         host_xfer(1'b0, a, 32'h0, 4'hF, rd, waited);
         check($sformatf("rnd_rd_w%0d", a), rd, ref_word(int'(a)));
      end
      d0 = done_cnt; crc = 16'h0;
      iCMD_START_TX = 1'b1; tick(); iCMD_START_TX = 1'b0;
      n = 0; cyc = 0; prev_rdy = 1'b1;
      while (n < 512 && cyc < 3000) begin
         iTX_READY = ($urandom_range(0, 3) != 0);
         #1;
         if (!prev_rdy) check($sformatf("rtx_hold%0d", n), oTX_BYTE, prev_byte);
         if (iTX_READY) begin
            check($sformatf("rtx_byte%0d", n), oTX_BYTE, ref_b[n]);
            crc = crc_model(crc, ref_b[n]);
            n++;
         end
         prev_byte = oTX_BYTE; prev_rdy = iTX_READY;
         tick(); cyc++;
      end
      iTX_READY = 1'b0;
      check("rtx_done", oDONE, 1);
      check("rtx_count", oBYTE_COUNT, 10'd512);
      check("rtx_crc", oCRC16, CRC_ON ? crc : 16'h0);
      tick();

      // Random RX with valid gaps
      crc = 16'h0;
      iCMD_START_RX = 1'b1; tick(); iCMD_START_RX = 1'b0;
      n = 0; cyc = 0;
      while (n < 512 && cyc < 3000) begin
         iRX_VALID = ($urandom_range(0, 2) != 0); b = 8'($urandom); iRX_BYTE = b;
         if (iRX_VALID) begin
            ref_b[n] = b; crc = crc_model(crc, b); n++;
         end
         tick(); cyc++;
      end
      iRX_VALID = 1'b0;
      check("rrx_done", oDONE, 1);
      check("rrx_crc", oCRC16, CRC_ON ? crc : 16'h0);
      check("rrx_done_count", done_cnt - d0, 1);
      tick();
      for (int i = 0; i < 8; i++) begin
         a = 7'($urandom);
         host_xfer(1'b0, a, 32'h0, 4'hF, rd, waited);
         check($sformatf("rrx_rd_w%0d", a), rd, ref_word(int'(a)));
      end

      // Reset at byte 100 aborts the sector
      d0 = done_cnt;
      iCMD_START_RX = 1'b1; tick(); iCMD_START_RX = 1'b0;
      for (int i = 0; i < 100; i++) begin
         iRX_VALID = 1'b1; iRX_BYTE = 8'(i + 7); ref_b[i] = 8'(i + 7);
         tick();
      end
      iRX_VALID = 1'b0;
      check("abort_count_100", oBYTE_COUNT, 10'd100);
      iRESET_SYNC = 1'b1; tick(); iRESET_SYNC = 1'b0;
      check("abort_busy", oBUSY, 0);
      check("abort_count", oBYTE_COUNT, 0);
      check("abort_done", oDONE, 0);
      check("abort_crc", oCRC16, 0);
      tick();
      check("abort_no_done", done_cnt - d0, 0);
      host_xfer(1'b0, 7'd24, 32'h0, 4'hF, rd, waited);
      check("abort_word24", rd, ref_word(24));
      host_xfer(1'b0, 7'd25, 32'h0, 4'hF, rd, waited);
      check("abort_word25", rd, ref_word(25));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
